// File: rtl/par2serial_tx.sv
// rtl/par2serial_tx.sv - PHY TX parallel-to-serial stage with COM alignment run
//
// Purpose: serialises one byte per frame, MSB first, on the bit clock.
//   After reset it sends COM_COUNT copies of COM_SYMBOL. It then loads data_in
//   when valid_in is set and IDLE_SYMBOL otherwise.
// Optional feature: define PAR2SERIAL_PARITY_EN to append one even-parity bit
//   per frame, which makes the frame 9 bits instead of 8.
// Ports:
//   sclk      in   bit clock; all logic on its rising edge
//   reset_L   in   synchronous active-low reset
//   data_in   in   [7:0] byte from the lane multiplexer, sampled on load edges
//   valid_in  in   qualifies data_in, sampled on load edges
//   ready     out  high in the cycle whose closing edge samples data_in/valid_in
//   active    out  high once the COM run is complete
//   data_out  out  registered serial bit stream
module par2serial_tx #(
   parameter int unsigned COM_COUNT   = 4,
   parameter logic [7:0]  COM_SYMBOL  = 8'hBC,
   parameter logic [7:0]  IDLE_SYMBOL = 8'h7C
) (
   input  logic       sclk,
   input  logic       reset_L,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready,
   output logic       active,
   output logic       data_out
);

`ifdef PAR2SERIAL_PARITY_EN
   localparam logic [3:0] LAST_BIT = 4'd8;
`else
   localparam logic [3:0] LAST_BIT = 4'd7;
`endif
   localparam logic [7:0] COM_LAST = 8'(COM_COUNT);

   typedef enum logic {SYNC, ACTIVE} state_t;

   state_t     state;
   logic [3:0] bit_cnt;
   logic [7:0] com_cnt;
   logic [7:0] shreg;
   logic [7:0] load_byte;
`ifdef PAR2SERIAL_PARITY_EN
   logic       parity;
`endif

   // Byte chosen for the next load edge. The inputs are only consumed when
   // bit_cnt is 0, so they have no effect outside the ready cycle.
   always_comb begin
      load_byte = COM_SYMBOL;
      if (state == ACTIVE) begin
         load_byte = valid_in ? data_in : IDLE_SYMBOL;
      end
   end

   always_ff @(posedge sclk) begin
      if (!reset_L) begin
         state    <= SYNC;
         bit_cnt  <= 4'd0;
         com_cnt  <= 8'd0;
         shreg    <= 8'd0;
         data_out <= 1'b0;
`ifdef PAR2SERIAL_PARITY_EN
         parity   <= 1'b0;
`endif
      end else begin
         if (bit_cnt == 4'd0) begin
            data_out <= load_byte[7];
            shreg    <= {load_byte[6:0], 1'b0};
`ifdef PAR2SERIAL_PARITY_EN
            parity   <= ^load_byte;
`endif
            if (state == SYNC) begin
               com_cnt <= com_cnt + 8'd1;
               if (com_cnt + 8'd1 == COM_LAST) begin
                  state <= ACTIVE;
               end
            end
         end
`ifdef PAR2SERIAL_PARITY_EN
         else if (bit_cnt == LAST_BIT) begin
            // The shift register is exhausted; the ninth bit is the saved parity.
            data_out <= parity;
         end
`endif
         else begin
            data_out <= shreg[7];
            shreg    <= {shreg[6:0], 1'b0};
         end
         bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
      end
   end

   // Both outputs are decoded from state registers only, so there is no path
   // from the inputs to them.
   assign ready  = (state == ACTIVE) && (bit_cnt == 4'd0);
   assign active = (state == ACTIVE);

endmodule
